timed_update_scheduler: RTL and testbench
=========================================

// Module: timed_update_scheduler
// PURPOSE
//  Queues timestamped update words and fires a single-cycle set strobe (plus payload) into a
//  downstream multibit set/reset latch when a free-running cycle timer reaches each entry's time.
//  Sits between the pulse-program/host write path and the output latch; all writes go through here.
//  Also issues a one-cycle clear strobe that flushes the queue and zeroes the latch.
// PARAMETERS
//  BITS        38  width of the set_data word forwarded to the latch
//  DATA_W      24  width of the auxiliary data word forwarded to the latch
//  TIME_W      32  width of the timer and of each entry timestamp
//  DEPTH_LOG2   4  queue depth = 2**DEPTH_LOG2 entries
// PORTS
//  clock          in   1             system clock, all logic on rising edge
//  reset          in   1             synchronous, active-high; returns block to reset state
//  enable         in   1             timer advances and entries may fire only while high
//  clear          in   1             flush queue, pulse reset_out
//  wr_en          in   1             push {wr_time,wr_set_data,wr_data} this cycle
//  wr_time        in   TIME_W        absolute fire time of pushed entry
//  wr_set_data    in   BITS          payload for latch q
//  wr_data        in   DATA_W        payload for latch data_buffer
//  full           out  1             queue holds 2**DEPTH_LOG2 entries
//  empty          out  1             queue holds 0 entries
//  count          out  DEPTH_LOG2+1  current occupancy
//  timer          out  TIME_W        free-running cycle counter
//  set_out        out  1             one-cycle strobe to latch set input
//  set_data_out   out  BITS          payload valid while set_out high
//  data_out       out  DATA_W        payload valid while set_out high
//  reset_out      out  1             one-cycle strobe to latch reset input
//  overflow       out  1             sticky: a push was dropped because full
//  late           out  1             sticky: an entry fired after its timestamp
// BEHAVIOUR
//  - Reset: all outputs 0 except empty=1; queue pointers, timer, and FSM cleared. Sticky flags
//    are cleared only by reset.
//  - Timer: increments by 1 each cycle enable=1; holds otherwise; wraps modulo 2**TIME_W.
//  - Queue: FIFO. Push with wr_en when not full. Push while full is dropped, sets overflow.
//    Push and pop in the same cycle are both honoured (count unchanged, also when full).
//  - Due test on head entry uses wrap-safe signed difference d = timer - head_time (TIME_W bits):
//    due when enable=1, empty=0, and d[TIME_W-1]=0 (d >= 0).
//  - FSM: IDLE (queue empty) -> WAIT (head present, not due) -> FIRE (one cycle) -> WAIT or IDLE.
//    In the cycle in which head is due, the head is popped. In the next cycle, set_out=1 and
//    set_data_out/data_out carry the popped payload (latency 1 from timer==time).
//    At most one entry fires per cycle. An entry due in the same cycle as a fire waits one cycle.
//  - If d > 0 at pop (timestamp already passed), the entry still fires and late is set.
//  - set_data_out/data_out hold their last value when set_out=0.
//  - clear (reset=0): in the same edge the queue is emptied and any pending pop is cancelled
//    (no set_out follows). reset_out=1 the next cycle. Timer and sticky flags are unaffected.
//    clear takes priority over wr_en and the due pop in the same cycle; the push is discarded,
//    and overflow is not set.
//  - set_out and reset_out are never high in the same cycle.
//  - reset during FIRE or with pending strobes suppresses the strobes; outputs are 0 next cycle.
//  - enable low freezes the timer and firing. Pushes still accepted.
// TESTING
//  1. reset, enable=1; push t=10 payload 0x3A/0x123456 at timer=2 -> set_out=1 only in cycle with
//     timer=11, set_data_out=0x3A, data_out=0x123456, late=0.
//  2. Push t=5,6,7 back-to-back before timer=5 -> three strobes at timer 6,7,8 in order. Then
//     empty=1 and FSM in IDLE.
//  3. Fill 16 entries, push a 17th -> full=1, overflow=1, count=16; the 17th is never output.
//     Simultaneous push+pop when full -> count stays 16.
//  4. Push t=3 when timer=20 -> set_out next cycle, late=1. Timer near 2**32-2, push t=1 ->
//     fires after wrap at timer=2, late=0.
//  5. Queue 4 entries and assert clear in the cycle the head is due -> no set_out, reset_out=1
//     one cycle later, count=0, same-cycle push discarded.
//  6. Drop enable for 5 cycles with head due at t=50 -> timer frozen, no fire. Fire at timer=51
//     after enable returns. reset mid-FIRE -> set_out=0 next cycle.

Source files
------------

// File: rtl/timed_update_scheduler.sv
// Timestamped update queue. When the free-running timer reaches the head entry's time, the
// entry is popped, and its payload is strobed into the downstream set/reset latch one cycle later.
module timed_update_scheduler #(
    parameter int BITS       = 38,
    parameter int DATA_W     = 24,
    parameter int TIME_W     = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                clear,
    input  logic                wr_en,
    input  logic [TIME_W-1:0]   wr_time,
    input  logic [BITS-1:0]     wr_set_data,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] count,
    output logic [TIME_W-1:0]   timer,
    output logic                set_out,
    output logic [BITS-1:0]     set_data_out,
    output logic [DATA_W-1:0]   data_out,
    output logic                reset_out,
    output logic                overflow,
    output logic                late,
    output logic [1:0]          fsm_state
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_FIRE = 2'd2} state_t;

    // wr_en is a push with no back-pressure: the writer watches full, and a push that
    // meets a full queue (with no pop in the same cycle) is dropped and flagged.
    logic [TIME_W-1:0]     time_mem [DEPTH];
    logic [BITS-1:0]       set_mem  [DEPTH];
    logic [DATA_W-1:0]     data_mem [DEPTH];

    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [TIME_W-1:0]     timer_q, diff;
    state_t                state_q;
    logic                  set_out_q, reset_out_q, overflow_q, late_q;
    logic [BITS-1:0]       set_data_q;
    logic [DATA_W-1:0]     data_q;
    logic                  due, pop, push, drop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // Signed wrap-safe comparison: the head is due once timer - head_time is non-negative.
    assign diff = timer_q - time_mem[rptr_q];
    assign due  = enable && !empty && !diff[TIME_W-1];
    assign pop  = due && !clear;
    assign push = wr_en && !clear && (!full || pop);
    assign drop = wr_en && !clear && full && !pop;

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (clear) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (pop)  rptr_d = rptr_q + DEPTH_LOG2'(1);
            if (push) wptr_d = wptr_q + DEPTH_LOG2'(1);
            if (push && !pop)      count_d = count_q + (DEPTH_LOG2+1)'(1);
            else if (pop && !push) count_d = count_q - (DEPTH_LOG2+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            time_mem[wptr_q] <= wr_time;
            set_mem[wptr_q]  <= wr_set_data;
            data_mem[wptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rptr_q      <= '0;
            wptr_q      <= '0;
            count_q     <= '0;
            timer_q     <= '0;
            set_out_q   <= 1'b0;
            set_data_q  <= '0;
            data_q      <= '0;
            reset_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            late_q      <= 1'b0;
        end else begin
            rptr_q      <= rptr_d;
            wptr_q      <= wptr_d;
            count_q     <= count_d;
            if (enable) timer_q <= timer_q + TIME_W'(1);
            set_out_q   <= pop;
            reset_out_q <= clear;
            if (pop) begin
                set_data_q <= set_mem[rptr_q];
                data_q     <= data_mem[rptr_q];
                if (diff != '0) late_q <= 1'b1;
            end
            if (drop) overflow_q <= 1'b1;
            if (clear)               state_q <= S_IDLE;
            else if (pop)            state_q <= S_FIRE;
            else if (count_d == '0)  state_q <= S_IDLE;
            else                     state_q <= S_WAIT;
        end
    end

    assign count        = count_q;
    assign timer        = timer_q;
    assign set_out      = set_out_q;
    assign set_data_out = set_data_q;
    assign data_out     = data_q;
    assign reset_out    = reset_out_q;
    assign overflow     = overflow_q;
    assign late         = late_q;
    assign fsm_state    = state_q;
endmodule

// File: tb/tb_timed_update_scheduler.sv
// Directed bench for timed_update_scheduler: a per-cycle vector table for basic firing,
// then hand-written sequences for overflow, late/wrap, clear, enable freeze and reset.
module tb_timed_update_scheduler;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_FIRE = 2'd2;

  logic clock = 1'b0;
  logic reset, enable, clear, wr_en, wr_en_w;
  logic [31:0] wr_time;
  logic [7:0]  wr_time_w;
  logic [37:0] wr_set_data;
  logic [23:0] wr_data;

  logic full, empty, set_out, reset_out, overflow, late;
  logic [4:0]  count;
  logic [31:0] timer;
  logic [37:0] set_data_out;
  logic [23:0] data_out;
  logic [1:0]  fsm_state;

  logic full_w, empty_w, set_out_w, reset_out_w, overflow_w, late_w;
  logic [4:0]  count_w;
  logic [7:0]  timer_w;
  logic [37:0] set_data_out_w;
  logic [23:0] data_out_w;
  logic [1:0]  fsm_state_w;

  int n_vec = 0;
  int n_err = 0;
  bit sb_on = 1'b0;
  logic [61:0] exp_q[$];

  timed_update_scheduler dut (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear), .wr_en(wr_en),
    .wr_time(wr_time), .wr_set_data(wr_set_data), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .timer(timer), .set_out(set_out),
    .set_data_out(set_data_out), .data_out(data_out), .reset_out(reset_out),
    .overflow(overflow), .late(late), .fsm_state(fsm_state)
  );

  // Narrow-timer instance so the wrap-around case is reachable in a few hundred cycles.
  timed_update_scheduler #(.TIME_W(8)) dut_w (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear), .wr_en(wr_en_w),
    .wr_time(wr_time_w), .wr_set_data(wr_set_data), .wr_data(wr_data),
    .full(full_w), .empty(empty_w), .count(count_w), .timer(timer_w), .set_out(set_out_w),
    .set_data_out(set_data_out_w), .data_out(data_out_w), .reset_out(reset_out_w),
    .overflow(overflow_w), .late(late_w), .fsm_state(fsm_state_w)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        wr;
    logic [31:0] wt;
    logic [37:0] ws;
    logic [23:0] wd;
    logic        e_set;
    logic [37:0] e_sd;
    logic [23:0] e_d;
    logic [4:0]  e_cnt;
    logic [31:0] e_tmr;
    logic [1:0]  e_st;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    if (sb_on && set_out) begin
      if (exp_q.size() == 0) check("sb_unexpected_set_out", 64'(set_out), 64'(0));
      else check("sb_payload", 64'({set_data_out, data_out}), 64'(exp_q.pop_front()));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic push(input logic [31:0] t, input logic [37:0] s, input logic [23:0] d,
                      input bit track);
    wr_en = 1'b1; wr_time = t; wr_set_data = s; wr_data = d;
    if (track) exp_q.push_back({s, d});
    step();
    wr_en = 1'b0;
  endtask

  task automatic add(input logic rst, input logic wr, input logic [31:0] wt,
                     input logic [37:0] ws, input logic [23:0] wd, input logic e_set,
                     input logic [37:0] e_sd, input logic [23:0] e_d, input logic [4:0] e_cnt,
                     input logic [31:0] e_tmr, input logic [1:0] e_st);
    vec_t v;
    v.rst = rst; v.wr = wr; v.wt = wt; v.ws = ws; v.wd = wd;
    v.e_set = e_set; v.e_sd = e_sd; v.e_d = e_d; v.e_cnt = e_cnt; v.e_tmr = e_tmr; v.e_st = e_st;
    tbl.push_back(v);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_empty"}, 64'(empty), 64'(1));
    check({tag, "_full"}, 64'(full), 64'(0));
    check({tag, "_count"}, 64'(count), 64'(0));
    check({tag, "_timer"}, 64'(timer), 64'(0));
    check({tag, "_set_out"}, 64'(set_out), 64'(0));
    check({tag, "_set_data_out"}, 64'(set_data_out), 64'(0));
    check({tag, "_data_out"}, 64'(data_out), 64'(0));
    check({tag, "_reset_out"}, 64'(reset_out), 64'(0));
    check({tag, "_overflow"}, 64'(overflow), 64'(0));
    check({tag, "_late"}, 64'(late), 64'(0));
  endtask

  initial begin
    bit found;
    reset = 1'b1; enable = 1'b1; clear = 1'b0; wr_en = 1'b0; wr_en_w = 1'b0;
    wr_time = '0; wr_time_w = '0; wr_set_data = '0; wr_data = '0;

    do_reset();
    check_reset_state("rst0");

    // Single entry t=10 pushed at timer=2, then three back-to-back entries t=5,6,7.
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ST_IDLE);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, ST_IDLE);
    add(0, 1, 10, 38'h3A, 24'h123456, 0, 0, 0, 1, 3, ST_WAIT);
    for (int t = 3; t <= 9; t++) add(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'(t + 1), ST_WAIT);
    add(0, 0, 0, 0, 0, 1, 38'h3A, 24'h123456, 0, 11, ST_FIRE);
    add(0, 0, 0, 0, 0, 0, 38'h3A, 24'h123456, 0, 12, ST_IDLE);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ST_IDLE);
    add(0, 1, 5, 38'h0100000001, 24'hAAAAAA, 0, 0, 0, 1, 1, ST_WAIT);
    add(0, 1, 6, 38'h2ABCDEF012, 24'hBBBBBB, 0, 0, 0, 2, 2, ST_WAIT);
    add(0, 1, 7, 38'h3FFFFFFFFF, 24'hCCCCCC, 0, 0, 0, 3, 3, ST_WAIT);
    add(0, 0, 0, 0, 0, 0, 0, 0, 3, 4, ST_WAIT);
    add(0, 0, 0, 0, 0, 0, 0, 0, 3, 5, ST_WAIT);
    add(0, 0, 0, 0, 0, 1, 38'h0100000001, 24'hAAAAAA, 2, 6, ST_FIRE);
    add(0, 0, 0, 0, 0, 1, 38'h2ABCDEF012, 24'hBBBBBB, 1, 7, ST_FIRE);
    add(0, 0, 0, 0, 0, 1, 38'h3FFFFFFFFF, 24'hCCCCCC, 0, 8, ST_FIRE);
    add(0, 0, 0, 0, 0, 0, 38'h3FFFFFFFFF, 24'hCCCCCC, 0, 9, ST_IDLE);

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; wr_en = tbl[i].wr; wr_time = tbl[i].wt;
      wr_set_data = tbl[i].ws; wr_data = tbl[i].wd;
      step();
      reset = 1'b0; wr_en = 1'b0;
      check($sformatf("tbl%0d_set_out", i), 64'(set_out), 64'(tbl[i].e_set));
      check($sformatf("tbl%0d_set_data_out", i), 64'(set_data_out), 64'(tbl[i].e_sd));
      check($sformatf("tbl%0d_data_out", i), 64'(data_out), 64'(tbl[i].e_d));
      check($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].e_cnt));
      check($sformatf("tbl%0d_timer", i), 64'(timer), 64'(tbl[i].e_tmr));
      check($sformatf("tbl%0d_state", i), 64'(fsm_state), 64'(tbl[i].e_st));
    end
    check("t2_empty", 64'(empty), 64'(1));
    check("t2_late", 64'(late), 64'(0));

    // Fill to 16, drop a 17th, then push while the head pops at a full queue.
    do_reset();
    sb_on = 1'b1;
    for (int i = 0; i < 16; i++)
      push((i == 0) ? 32'd20 : 32'(1000 + i), 38'h100 + 38'(i), 24'h5000 + 24'(i), 1'b1);
    check("fill_count", 64'(count), 64'(16));
    check("fill_full", 64'(full), 64'(1));
    check("fill_overflow", 64'(overflow), 64'(0));
    push(32'd1500, 38'h3ABCD, 24'hDEAD, 1'b0);
    check("drop_overflow", 64'(overflow), 64'(1));
    check("drop_count", 64'(count), 64'(16));
    repeat (3) step();
    check("pp_timer_before", 64'(timer), 64'(20));
    push(32'd2000, 38'h777, 24'h7777, 1'b1);
    check("pp_set_out", 64'(set_out), 64'(1));
    check("pp_count", 64'(count), 64'(16));
    check("pp_full", 64'(full), 64'(1));
    for (int i = 0; i < 2100 && timer < 32'd2005; i++) step();
    check("fill_drained", 64'(exp_q.size()), 64'(0));
    check("fill_end_empty", 64'(empty), 64'(1));
    check("fill_end_late", 64'(late), 64'(0));
    sb_on = 1'b0;

    // Entry whose timestamp has already passed fires immediately and sets late.
    do_reset();
    sb_on = 1'b1;
    repeat (20) step();
    push(32'd3, 38'h1234567, 24'h00BEEF, 1'b1);
    check("late_pre_count", 64'(count), 64'(1));
    check("late_pre_late", 64'(late), 64'(0));
    step();
    check("late_set_out", 64'(set_out), 64'(1));
    check("late_timer", 64'(timer), 64'(22));
    check("late_flag", 64'(late), 64'(1));
    check("late_drained", 64'(exp_q.size()), 64'(0));
    sb_on = 1'b0;

    // Timer wrap on the 8-bit instance: t=1 pushed at 254 fires at timer 2, not late.
    do_reset();
    repeat (254) step();
    check("wrap_timer_pre", 64'(timer_w), 64'(254));
    wr_en_w = 1'b1; wr_time_w = 8'd1; wr_set_data = 38'h2_0000_0002; wr_data = 24'h0F0F0F;
    step();
    wr_en_w = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (set_out_w) found = 1'b1;
    end
    check("wrap_fired", 64'(found), 64'(1));
    check("wrap_timer", 64'(timer_w), 64'(2));
    check("wrap_late", 64'(late_w), 64'(0));
    check("wrap_payload", 64'({set_data_out_w, data_out_w}), {2'b0, 38'h2_0000_0002, 24'h0F0F0F});

    // Clear in the cycle the head is due, with a push in the same cycle.
    do_reset();
    for (int i = 0; i < 4; i++) push(32'(10 + i), 38'h40 + 38'(i), 24'h40 + 24'(i), 1'b0);
    repeat (6) step();
    check("clr_pre_timer", 64'(timer), 64'(10));
    clear = 1'b1; wr_en = 1'b1; wr_time = 32'd50; wr_set_data = 38'h55; wr_data = 24'h55;
    step();
    clear = 1'b0; wr_en = 1'b0;
    check("clr_set_out", 64'(set_out), 64'(0));
    check("clr_reset_out", 64'(reset_out), 64'(1));
    check("clr_count", 64'(count), 64'(0));
    check("clr_timer", 64'(timer), 64'(11));
    check("clr_overflow", 64'(overflow), 64'(0));
    check("clr_state", 64'(fsm_state), 64'(ST_IDLE));
    sb_on = 1'b1;
    step();
    check("clr_reset_out_once", 64'(reset_out), 64'(0));
    for (int i = 0; i < 60; i++) step();
    check("clr_end_empty", 64'(empty), 64'(1));
    sb_on = 1'b0;

    // Enable low with the head due freezes timer and firing; then reset while a strobe is pending.
    do_reset();
    push(32'd50, 38'h50, 24'h500050, 1'b0);
    repeat (49) step();
    check("en_timer_pre", 64'(timer), 64'(50));
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("en_frozen_timer%0d", i), 64'(timer), 64'(50));
      check($sformatf("en_frozen_set_out%0d", i), 64'(set_out), 64'(0));
    end
    check("en_frozen_count", 64'(count), 64'(1));
    enable = 1'b1;
    step();
    check("en_fire_timer", 64'(timer), 64'(51));
    check("en_fire_set_out", 64'(set_out), 64'(1));
    check("en_fire_payload", 64'({set_data_out, data_out}), {2'b0, 38'h50, 24'h500050});
    check("en_fire_late", 64'(late), 64'(0));
    push(32'd60, 38'h60, 24'h600060, 1'b0);
    push(32'd61, 38'h61, 24'h610061, 1'b0);
    repeat (8) step();
    check("rf_set_out", 64'(set_out), 64'(1));
    check("rf_timer", 64'(timer), 64'(61));
    check("rf_payload", 64'(set_data_out), 64'(38'h60));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_state("rf");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
